// File: rtl/bias_fetch_ctrl_if.sv
// Bias fetch bus: ROM request/response signals plus the bias vector stream
// toward the systolic array. The controller drives the master modport; the
// ROM and the array consumer together sit on the slave modport.
interface bias_fetch_ctrl_if #(
   parameter int DW      = 8,
   parameter int COLS    = 8,
   parameter int ADDR_DW = 8
);
   logic                 rom_initial_sig;
   logic                 rom_mem_sig;
   logic [ADDR_DW-1:0]   rom_addr;
   logic                 rom_rd_valid;
   logic [15:0]          rom_kernel_num;
   logic [DW*COLS-1:0]   rom_data;
   logic [DW*COLS-1:0]   bias_data;
   logic                 bias_valid;
   logic                 bias_ready;
   logic                 bias_last;

   modport master (
      output rom_initial_sig, rom_addr, rom_rd_valid, rom_kernel_num,
      output bias_data, bias_valid, bias_last,
      input  rom_mem_sig, rom_data, bias_ready
   );

   modport slave (
      input  rom_initial_sig, rom_addr, rom_rd_valid, rom_kernel_num,
      input  bias_data, bias_valid, bias_last,
      output rom_mem_sig, rom_data, bias_ready
   );
endinterface

// File: rtl/bias_fetch_ctrl.sv
// Bias fetch controller: per layer, initialises the bias ROM, reads
// ceil(kernel_num/COLS) bias groups one at a time and presents each as a
// registered valid/ready vector to the systolic array, then pulses done.
// Optional feature: define BIAS_FETCH_STALL_CNT_EN to add the 32-bit
// saturating stall_cnt output (HOLD cycles with bias_ready low).
module bias_fetch_ctrl #(
   parameter int DW      = 8,
   parameter int COLS    = 8,
   parameter int ADDR_DW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       kernel_num,
   output logic              busy,
   output logic              done,
   bias_fetch_ctrl_if.master bus
`ifdef BIAS_FETCH_STALL_CNT_EN
   ,output logic [31:0]      stall_cnt
`endif
);

   // Group counters are wide enough for any 16-bit kernel count and for
   // one more than the largest ROM address.
   localparam int GW = (ADDR_DW + 1 > 17) ? ADDR_DW + 1 : 17;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] INIT  = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]          state_reg, state_next;
   logic [GW-1:0]       grp_reg;
   logic [GW-1:0]       grp_total_reg;
   logic [GW-1:0]       grp_plus;
   logic [GW-1:0]       grp_calc;
   logic [ADDR_DW-1:0]  rom_addr_reg;
   logic [15:0]         kernel_num_reg;
   logic [DW*COLS-1:0]  bias_data_reg;
   logic                bias_valid_reg;
   logic                bias_last_reg;
   logic                done_reg;
   logic                start_ok;
   logic                handshake;

   assign start_ok  = (state_reg == IDLE) && start && !abort;
   assign handshake = (state_reg == HOLD) && bias_valid_reg && bus.bias_ready;
   assign grp_plus  = grp_reg + GW'(1);
   assign grp_calc  = (GW'(kernel_num) + GW'(COLS - 1)) / GW'(COLS);

   assign busy                = (state_reg != IDLE);
   assign done                = done_reg;
   assign bus.rom_initial_sig = (state_reg == INIT);
   assign bus.rom_rd_valid    = (state_reg == ISSUE);
   assign bus.rom_addr        = rom_addr_reg;
   assign bus.rom_kernel_num  = kernel_num_reg;
   assign bus.bias_data       = bias_data_reg;
   assign bus.bias_valid      = bias_valid_reg;
   assign bus.bias_last       = bias_last_reg;

   // Next-state decode; abort overrides every other condition.
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start) state_next = (kernel_num == 16'd0) ? DONE : INIT;
            INIT:    if (bus.rom_mem_sig) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = HOLD;
            HOLD:    if (bus.bias_ready) state_next = (grp_plus < grp_total_reg) ? ISSUE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Layer bookkeeping, ROM address and the registered bias vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_reg        <= '0;
         grp_total_reg  <= '0;
         rom_addr_reg   <= '0;
         kernel_num_reg <= '0;
         bias_data_reg  <= '0;
         bias_valid_reg <= 1'b0;
         bias_last_reg  <= 1'b0;
      end else if (abort) begin
         grp_reg        <= '0;
         bias_valid_reg <= 1'b0;
         bias_last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  kernel_num_reg <= kernel_num;
                  grp_total_reg  <= grp_calc;
                  grp_reg        <= '0;
               end
            end
            INIT: begin
               // Address is set up on entry to ISSUE so it is valid with the strobe.
               if (bus.rom_mem_sig) rom_addr_reg <= grp_reg[ADDR_DW-1:0];
            end
            WAIT: begin
               bias_data_reg  <= bus.rom_data;
               bias_valid_reg <= 1'b1;
               bias_last_reg  <= (grp_reg == grp_total_reg - GW'(1));
            end
            HOLD: begin
               if (handshake) begin
                  grp_reg        <= grp_plus;
                  bias_valid_reg <= 1'b0;
                  bias_last_reg  <= 1'b0;
                  if (grp_plus < grp_total_reg) rom_addr_reg <= grp_plus[ADDR_DW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Completion pulse follows the DONE state; suppressed by abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_reg <= 1'b0;
      else        done_reg <= (state_reg == DONE) && !abort;
   end

`ifdef BIAS_FETCH_STALL_CNT_EN
   // Saturating count of HOLD cycles where the consumer is not ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (start_ok) begin
         stall_cnt <= '0;
      end else if ((state_reg == HOLD) && !bus.bias_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Directed bench for bias_fetch_ctrl (DW=8, COLS=8, ADDR_DW=8) with a
// one-cycle-latency ROM model. Build with BIAS_FETCH_STALL_CNT_EN defined
// to include the stall counter checks.
module tb_bias_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] kernel_num;
   logic        busy;
   logic        done;
`ifdef BIAS_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   int vectors = 0;
   int miscompares = 0;
   int rd_cnt = 0;

   bias_fetch_ctrl_if #(.DW(8), .COLS(8), .ADDR_DW(8)) bus ();

   bias_fetch_ctrl #(.DW(8), .COLS(8), .ADDR_DW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .kernel_num (kernel_num),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
`ifdef BIAS_FETCH_STALL_CNT_EN
      ,.stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rom_pat(input logic [7:0] a);
      return {8{a}} ^ 64'hA5C3_0F1E_7B2D_9684;
   endfunction

   // ROM model: data one cycle after the read strobe; counts reads.
   always @(posedge clk) begin
      if (bus.rom_rd_valid) begin
         bus.rom_data <= rom_pat(bus.rom_addr);
         rd_cnt       <= rd_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vectors++;
      if ({busy, done, bus.bias_valid, bus.bias_last, bus.rom_rd_valid, bus.rom_initial_sig} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000000", {busy, done, bus.bias_valid, bus.bias_last, bus.rom_rd_valid, bus.rom_initial_sig});
      end
      vectors++;
      if (bus.rom_addr !== 8'd0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", bus.rom_addr); end
      vectors++;
      if (bus.rom_kernel_num !== 16'd0) begin miscompares++; $display("FAIL reset_kn: got %0h want 0", bus.rom_kernel_num); end
      vectors++;
      if (bus.bias_data !== 64'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.bias_data); end
`ifdef BIAS_FETCH_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
      $display("test_reset: %0d vectors, %0d miscompares so far", vectors, miscompares);
   endtask

   // kernel_num=20: groups 0,1,2; 3 cycles per group with ready high.
   task automatic test_basic(input string tag);
      logic [15:0] e_rdv, e_val, e_last, e_done, e_busy, e_init;
      e_rdv  = 16'h0124;
      e_val  = 16'h0490;
      e_last = 16'h0400;
      e_done = 16'h1000;
      e_busy = 16'h0FFE;
      e_init = 16'h0002;
      kernel_num = 16'd20; bus.bias_ready = 1'b1; bus.rom_mem_sig = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         vectors++;
         if (bus.rom_rd_valid !== e_rdv[c]) begin miscompares++; $display("FAIL %s rd_valid c%0d: got %b want %b", tag, c, bus.rom_rd_valid, e_rdv[c]); end
         if (e_rdv[c]) begin
            vectors++;
            if (bus.rom_addr !== 8'((c - 2) / 3)) begin miscompares++; $display("FAIL %s addr c%0d: got %0d want %0d", tag, c, bus.rom_addr, (c - 2) / 3); end
         end
         vectors++;
         if (bus.bias_valid !== e_val[c]) begin miscompares++; $display("FAIL %s valid c%0d: got %b want %b", tag, c, bus.bias_valid, e_val[c]); end
         if (e_val[c]) begin
            vectors++;
            if (bus.bias_data !== rom_pat(8'((c - 4) / 3))) begin miscompares++; $display("FAIL %s data c%0d: got %h want %h", tag, c, bus.bias_data, rom_pat(8'((c - 4) / 3))); end
            vectors++;
            if (bus.bias_last !== e_last[c]) begin miscompares++; $display("FAIL %s last c%0d: got %b want %b", tag, c, bus.bias_last, e_last[c]); end
         end
         vectors++;
         if (done !== e_done[c]) begin miscompares++; $display("FAIL %s done c%0d: got %b want %b", tag, c, done, e_done[c]); end
         vectors++;
         if (busy !== e_busy[c]) begin miscompares++; $display("FAIL %s busy c%0d: got %b want %b", tag, c, busy, e_busy[c]); end
         vectors++;
         if (bus.rom_initial_sig !== e_init[c]) begin miscompares++; $display("FAIL %s init_sig c%0d: got %b want %b", tag, c, bus.rom_initial_sig, e_init[c]); end
         tick();
      end
      vectors++;
      if (bus.rom_kernel_num !== 16'd20) begin miscompares++; $display("FAIL %s kernel_num: got %0d want 20", tag, bus.rom_kernel_num); end
      $display("test_basic(%s): %0d vectors, %0d miscompares so far", tag, vectors, miscompares);
   endtask

   task automatic test_zero_kernel();
      int base;
      base = rd_cnt;
      kernel_num = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL zero c1 busy/done: got %b want 10", {busy, done}); end
      tick();
      vectors++;
      if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL zero c2 busy/done: got %b want 01", {busy, done}); end
      tick();
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL zero c3 done: got %b want 0", done); end
      vectors++;
      if (rd_cnt != base) begin miscompares++; $display("FAIL zero reads: got %0d want 0", rd_cnt - base); end
      $display("test_zero_kernel: %0d vectors, %0d miscompares so far", vectors, miscompares);
   endtask

   task automatic test_init_wait();
      int seen;
      kernel_num = 16'd8; bus.rom_mem_sig = 1'b0; bus.bias_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         vectors++;
         if ({bus.rom_initial_sig, bus.rom_rd_valid} !== 2'b10) begin miscompares++; $display("FAIL init_wait c%0d init/rd: got %b want 10", c, {bus.rom_initial_sig, bus.rom_rd_valid}); end
         tick();
      end
      bus.rom_mem_sig = 1'b1;
      vectors++;
      if ({bus.rom_initial_sig, bus.rom_rd_valid} !== 2'b10) begin miscompares++; $display("FAIL init_wait rise init/rd: got %b want 10", {bus.rom_initial_sig, bus.rom_rd_valid}); end
      tick();
      vectors++;
      if ({bus.rom_initial_sig, bus.rom_rd_valid} !== 2'b01) begin miscompares++; $display("FAIL init_wait issue init/rd: got %b want 01", {bus.rom_initial_sig, bus.rom_rd_valid}); end
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 1) begin miscompares++; $display("FAIL init_wait done pulses: got %0d want 1", seen); end
      $display("test_init_wait: %0d vectors, %0d miscompares so far", vectors, miscompares);
   endtask

   task automatic test_stall();
      int base, seen;
      base = rd_cnt;
      kernel_num = 16'd20; bus.rom_mem_sig = 1'b1; bus.bias_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      bus.bias_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (bus.bias_valid !== 1'b1 || bus.bias_data !== rom_pat(8'd1) || bus.bias_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stall hold k%0d: got v=%b d=%h l=%b want v=1 d=%h l=0", k, bus.bias_valid, bus.bias_data, bus.bias_last, rom_pat(8'd1));
         end
         vectors++;
         if (bus.rom_rd_valid !== 1'b0) begin miscompares++; $display("FAIL stall rd_valid k%0d: got %b want 0", k, bus.rom_rd_valid); end
         tick();
      end
      vectors++;
      if (rd_cnt - base != 2) begin miscompares++; $display("FAIL stall reads: got %0d want 2", rd_cnt - base); end
`ifdef BIAS_FETCH_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== 32'd5) begin miscompares++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
      bus.bias_ready = 1'b1;
      tick();
      vectors++;
      if (bus.rom_rd_valid !== 1'b1 || bus.rom_addr !== 8'd2) begin miscompares++; $display("FAIL stall resume: got rd=%b addr=%0d want rd=1 addr=2", bus.rom_rd_valid, bus.rom_addr); end
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 1) begin miscompares++; $display("FAIL stall done pulses: got %0d want 1", seen); end
      $display("test_stall: %0d vectors, %0d miscompares so far", vectors, miscompares);
   endtask

   task automatic test_abort();
      int seen;
      kernel_num = 16'd16; bus.rom_mem_sig = 1'b1; bus.bias_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      vectors++;
      if (bus.bias_valid !== 1'b1) begin miscompares++; $display("FAIL abort pre valid: got %b want 1", bus.bias_valid); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++;
      if ({busy, bus.bias_valid, bus.bias_last, bus.rom_rd_valid} !== 4'b0) begin miscompares++; $display("FAIL abort state: got busy/v/l/rd=%b want 0000", {busy, bus.bias_valid, bus.bias_last, bus.rom_rd_valid}); end
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 0) begin miscompares++; $display("FAIL abort done pulses: got %0d want 0", seen); end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      vectors++;
      if (bus.rom_rd_valid !== 1'b1 || bus.rom_addr !== 8'd0) begin miscompares++; $display("FAIL abort restart: got rd=%b addr=%0d want rd=1 addr=0", bus.rom_rd_valid, bus.rom_addr); end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 1) begin miscompares++; $display("FAIL abort restart done pulses: got %0d want 1", seen); end
      $display("test_abort: %0d vectors, %0d miscompares so far", vectors, miscompares);
   endtask

   task automatic test_reset_mid();
      int seen;
      kernel_num = 16'd20; bus.rom_mem_sig = 1'b1; bus.bias_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      vectors++;
      if (busy !== 1'b1 || bus.rom_addr !== 8'd1) begin miscompares++; $display("FAIL rmid pre: got busy=%b addr=%0d want busy=1 addr=1", busy, bus.rom_addr); end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, bus.bias_valid, bus.bias_last, bus.rom_rd_valid, bus.rom_initial_sig} !== 6'b0) begin miscompares++; $display("FAIL rmid flags: got %b want 000000", {busy, done, bus.bias_valid, bus.bias_last, bus.rom_rd_valid, bus.rom_initial_sig}); end
      vectors++;
      if (bus.rom_addr !== 8'd0 || bus.rom_kernel_num !== 16'd0 || bus.bias_data !== 64'd0) begin miscompares++; $display("FAIL rmid regs: got addr=%0d kn=%0d data=%h want 0", bus.rom_addr, bus.rom_kernel_num, bus.bias_data); end
      #1 rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0) begin miscompares++; $display("FAIL rmid after reset busy/done cycles: got %0d want 0", seen); end
      kernel_num = 16'd8;
      start = 1'b1;
      tick();
      kernel_num = 16'd0;
      tick();
      start = 1'b0;
      vectors++;
      if (bus.rom_rd_valid !== 1'b1 || bus.rom_kernel_num !== 16'd8) begin miscompares++; $display("FAIL busy start: got rd=%b kn=%0d want rd=1 kn=8", bus.rom_rd_valid, bus.rom_kernel_num); end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      vectors++;
      if (seen != 1) begin miscompares++; $display("FAIL busy start done pulses: got %0d want 1", seen); end
      $display("test_reset_mid: %0d vectors, %0d miscompares so far", vectors, miscompares);
      test_basic("post_reset");
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; kernel_num = 16'd0;
      bus.rom_mem_sig = 1'b1; bus.bias_ready = 1'b1; bus.rom_data = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_basic("basic");
      test_zero_kernel();
      test_init_wait();
      test_stall();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
